// File: rtl/peg_rand_vec_sched.sv
// Round-robin scheduler that fills a granted request with LFSR bytes, one byte
// per cycle, and returns the vector zero-masked above the requested length.
module peg_rand_vec_sched #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_FIELD_LEN = 256,
  parameter int unsigned LEN_W         = 9,
  parameter logic [31:0] LFSR_SEED     = 32'hACE1_2468
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_vld,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  output logic [NUM_REQ-1:0]         req_rdy,
  output logic                       rsp_vld,
  input  logic                       rsp_rdy,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [LEN_W-1:0]           rsp_len,
  output logic [MAX_FIELD_LEN-1:0]   rsp_data,
  input  logic                       seed_load,
  input  logic [31:0]                seed_val,
  output logic                       busy
);

  localparam int unsigned ID_W      = $clog2(NUM_REQ);
  localparam int unsigned NBYTE_MAX = MAX_FIELD_LEN / 8;
  localparam int unsigned BYTE_W    = $clog2(NBYTE_MAX + 1);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [31:0]              lfsr_q, lfsr_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]          rsp_id_q, rsp_id_d;
  logic [LEN_W-1:0]         rsp_len_q, rsp_len_d;
  logic [BYTE_W-1:0]        nbytes_q, nbytes_d;
  logic [BYTE_W-1:0]        byte_idx_q, byte_idx_d;
  logic [MAX_FIELD_LEN-1:0] rsp_data_q, rsp_data_d;
  logic                     rsp_vld_q, rsp_vld_d;
  logic                     busy_q, busy_d;

  logic [31:0]              lfsr_adv;
  logic                     gnt_found;
  logic [ID_W-1:0]          gnt_idx;
  logic [LEN_W-1:0]         gnt_len;
  logic [LEN_W-1:0]         gnt_eff;
  logic [LEN_W:0]           gnt_len_rnd;
  logic [BYTE_W-1:0]        gnt_nbytes;
  logic                     grant_c;
  logic                     last_byte;
  logic [2:0]               tail_bits;
  logic [7:0]               byte_mask;
  int unsigned              cand;

  // Eight Galois steps of the LFSR in one cycle
  always_comb begin
    lfsr_adv = lfsr_q;
    for (int unsigned s = 0; s < 8; s++) begin
      lfsr_adv = {1'b0, lfsr_adv[31:1]} ^ (lfsr_adv[0] ? LFSR_MASK : 32'h0);
    end
  end

  // Round-robin search upward from rr_ptr with wrap-around
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!gnt_found && req_vld[ID_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  // Length of the granted requester, clamped, and its byte count
  always_comb begin
    gnt_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) gnt_len = req_len[i*LEN_W +: LEN_W];
    end
    gnt_eff     = (gnt_len > LEN_W'(MAX_FIELD_LEN)) ? LEN_W'(MAX_FIELD_LEN) : gnt_len;
    gnt_len_rnd = {1'b0, gnt_eff} + (LEN_W+1)'(7);
    gnt_nbytes  = BYTE_W'(gnt_len_rnd >> 3);
  end

  // Grant pulse is issued in the same cycle the IDLE state sees the request
  always_comb begin
    grant_c = (state_q == ST_IDLE) && !seed_load && gnt_found && !rst;
    req_rdy = grant_c ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  // Mask for the partial last byte so bits at or above the length stay zero
  always_comb begin
    last_byte = (byte_idx_q == nbytes_q - BYTE_W'(1));
    tail_bits = rsp_len_q[2:0];
    byte_mask = (last_byte && (tail_bits != 3'd0))
                ? (8'hFF >> (4'd8 - {1'b0, tail_bits}))
                : 8'hFF;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_len_d  = rsp_len_q;
    nbytes_d   = nbytes_q;
    byte_idx_d = byte_idx_q;
    rsp_data_d = rsp_data_q;

    case (state_q)
      ST_IDLE: begin
        if (seed_load) begin
          lfsr_d = (seed_val == 32'h0) ? LFSR_SEED : seed_val;
        end else if (gnt_found) begin
          rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          rsp_id_d   = gnt_idx;
          rsp_len_d  = gnt_eff;
          nbytes_d   = gnt_nbytes;
          byte_idx_d = '0;
          rsp_data_d = '0;
          state_d    = (gnt_eff == '0) ? ST_RESP : ST_GEN;
        end
      end
      ST_GEN: begin
        rsp_data_d[{byte_idx_q, 3'b000} +: 8] = lfsr_q[7:0] & byte_mask;
        lfsr_d     = lfsr_adv;
        byte_idx_d = byte_idx_q + BYTE_W'(1);
        if (last_byte) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_rdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_vld_d = (state_d == ST_RESP);
    busy_d    = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= LFSR_SEED;
      rr_ptr_q   <= '0;
      rsp_id_q   <= '0;
      rsp_len_q  <= '0;
      nbytes_q   <= '0;
      byte_idx_q <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_len_q  <= rsp_len_d;
      nbytes_q   <= nbytes_d;
      byte_idx_q <= byte_idx_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
      busy_q     <= busy_d;
    end
  end

  assign rsp_vld  = rsp_vld_q;
  assign rsp_id   = rsp_id_q;
  assign rsp_len  = rsp_len_q;
  assign rsp_data = rsp_data_q;
  assign busy     = busy_q;

endmodule
